full_adder: RTL and testbench
=============================

// Module: full_adder
// PURPOSE
//  Binary full adder: sums operands a and b with carry-in ci, producing sum s and carry-out cout.
//  Combinational outputs give the zero-latency result. Registered copies give a one-cycle-latency result for timing-closed datapaths.
//  Default WIDTH=1 is the classic 1-bit cell. Larger WIDTH forms a ripple-carry adder used as an arithmetic leaf block.
// PARAMETERS
//  WIDTH   1   operand/sum width in bits (>=1)
// PORTS
//  clk     in   1      single clock; all registers update on rising edge
//  rst     in   1      synchronous, active-high reset
//  a       in   WIDTH  operand A
//  b       in   WIDTH  operand B
//  ci      in   1      carry-in
//  s       out  WIDTH  combinational sum, (a+b+ci) mod 2^WIDTH
//  cout    out  1      combinational carry-out, bit WIDTH of a+b+ci
//  s_q     out  WIDTH  registered s
//  cout_q  out  1      registered cout
// BEHAVIOUR
//  - Interface: one clock (clk); reset rst is synchronous and active-high.
//  - s/cout: purely combinational, zero latency. They are independent of clk and rst.
//    They settle within the same delta/timestep as any input change.
//  - Bit cell i: s[i] = a[i]^b[i]^c[i].
//    c[i+1] = (a[i]&b[i]) | (a[i]&c[i]) | (b[i]&c[i]).
//    c[0] = ci; cout = c[WIDTH].
//  - Arithmetic: {cout,s} == a + b + ci exactly (WIDTH+1-bit unsigned result).
//    No overflow flag; signed interpretation is left to the user.
//  - Registered path: on each rising clk, s_q<=s and cout_q<=cout, giving 1-cycle latency.
//  - Reset: while rst=1 at a rising edge, s_q<=0 and cout_q<=0. Reset has priority over the data load.
//  - Reset mid-operation: the combinational outputs keep tracking the inputs.
//    Registered outputs resume on the first edge with rst=0.
//  - X/Z on any input propagates per standard Verilog operators. No X-masking logic.
//  - No enables, no handshake, no state machine.
// STRUCTURE
//  - No shared package needed. The only parameter is WIDTH.
//  - Sub-module full_adder_bit (a,b,ci -> s,cout) is a pure combinational 1-bit cell.
//  - full_adder instantiates WIDTH full_adder_bit cells in a generate loop, chaining carries.
//  - The output register is an always @(posedge clk) block.
// TESTING
//  - WIDTH=1, exhaustive sweep of {a,b,ci} = 000..111, 10 ns apart. Required combinational {cout,s}:
//    000->00, 001->01, 010->01, 011->10, 100->01, 101->10, 110->10, 111->11.
//  - WIDTH=1, a=1 b=1 ci=1 held -> s=1, cout=1 immediately.
//    After one rising clk: s_q=1, cout_q=1.
//  - Reset: rst=1 for 2 edges with inputs 111 -> s_q=0, cout_q=0, while s=1 and cout=1.
//    Deassert rst -> s_q=1, cout_q=1 after the next edge.
//  - WIDTH=4, a=4'hF b=4'h0 ci=1 -> s=4'h0, cout=1 (full carry ripple).
//    a=4'h7 b=4'h8 ci=0 -> s=4'hF, cout=0.
//  - WIDTH=8, random a/b/ci for 1000 cycles.
//    Check {cout,s}==a+b+ci every cycle; check {cout_q,s_q} equals the previous cycle's value.
//  - Inputs change mid-cycle -> s/cout follow at once; s_q/cout_q change only at a rising edge.

Source files
------------

// File: rtl/full_adder_pkg.sv
// Shared definitions for the ripple-carry full adder slice.
package full_adder_pkg;

   // Default operand width: the classic 1-bit cell
   localparam int unsigned FA_DEFAULT_WIDTH = 1;

   // Majority of three inputs: the carry-out of one adder cell
   function automatic logic maj3(input logic x, input logic y, input logic z);
      return (x & y) | (x & z) | (y & z);
   endfunction

endpackage

// File: rtl/full_adder_bit.sv
// Purely combinational 1-bit full adder cell.
module full_adder_bit
   import full_adder_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic cout
);

   // Sum is the three-way parity, carry is the majority
   always_comb begin
      s    = a ^ b ^ ci;
      cout = maj3(a, b, ci);
   end

endmodule

// File: rtl/full_adder.sv
// Ripple-carry adder built from full_adder_bit cells, with a registered copy
// of the result for timing-closed datapaths.
module full_adder
   import full_adder_pkg::*;
#(
   parameter int unsigned WIDTH = FA_DEFAULT_WIDTH
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic [WIDTH-1:0] s_q,
   output logic             cout_q
);

   // c[i] is the carry into bit i; c[WIDTH] leaves the chain
   logic [WIDTH:0] c;

   assign c[0] = ci;

   // One cell per bit, carries chained low to high
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      full_adder_bit u_bit (
         .a    (a[i]),
         .b    (b[i]),
         .ci   (c[i]),
         .s    (s[i]),
         .cout (c[i+1])
      );
   end

   assign cout = c[WIDTH];

   // Output register: synchronous reset takes priority over the load
   always_ff @(posedge clk) begin
      if (rst) begin
         s_q    <= '0;
         cout_q <= 1'b0;
      end else begin
         s_q    <= s;
         cout_q <= cout;
      end
   end

endmodule

// File: tb/tb_full_adder.sv
// Directed and random checks of full_adder at WIDTH 1, 4 and 8.
module tb_full_adder;

   logic       clk;
   logic       rst;

   logic       a1, b1, ci1, s1, cout1, s1_q, cout1_q;
   logic [3:0] a4, b4, s4, s4_q;
   logic       ci4, cout4, cout4_q;
   logic [7:0] a8, b8, s8, s8_q;
   logic       ci8, cout8, cout8_q;

   int tests;
   int fails;

   full_adder #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst(rst), .a(a1), .b(b1), .ci(ci1),
      .s(s1), .cout(cout1), .s_q(s1_q), .cout_q(cout1_q)
   );

   full_adder #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst(rst), .a(a4), .b(b4), .ci(ci4),
      .s(s4), .cout(cout4), .s_q(s4_q), .cout_q(cout4_q)
   );

   full_adder #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .a(a8), .b(b8), .ci(ci8),
      .s(s8), .cout(cout8), .s_q(s8_q), .cout_q(cout8_q)
   );

   // 10 ns clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [1:0] tbl1 [8];
      logic [2:0] v;
      logic [8:0] exp8;
      logic [8:0] prev8;

      tests = 0;
      fails = 0;
      tbl1[0] = 2'b00; tbl1[1] = 2'b01; tbl1[2] = 2'b01; tbl1[3] = 2'b10;
      tbl1[4] = 2'b01; tbl1[5] = 2'b10; tbl1[6] = 2'b10; tbl1[7] = 2'b11;

      rst = 1'b1;
      a1 = 1'b0; b1 = 1'b0; ci1 = 1'b0;
      a4 = 4'h0; b4 = 4'h0; ci4 = 1'b0;
      a8 = 8'h0; b8 = 8'h0; ci8 = 1'b0;

      // Reset state after two edges
      @(posedge clk); @(posedge clk); #1;
      chk("rst_w1_q", 9'({cout1_q, s1_q}), 9'h0);
      chk("rst_w4_q", 9'({cout4_q, s4_q}), 9'h0);
      chk("rst_w8_q", 9'({cout8_q, s8_q}), 9'h0);

      @(negedge clk);
      rst = 1'b0;

      // Exhaustive 1-bit sweep, combinational then registered
      for (int i = 0; i < 8; i++) begin
         v = 3'(i);
         {a1, b1, ci1} = v;
         #1;
         chk($sformatf("w1_comb_%0d", i), 9'({cout1, s1}), 9'(tbl1[i]));
         @(posedge clk); #1;
         chk($sformatf("w1_reg_%0d", i), 9'({cout1_q, s1_q}), 9'(tbl1[i]));
         @(negedge clk);
      end

      // 111 held, then reset asserted for two edges
      {a1, b1, ci1} = 3'b111;
      #1;
      chk("w1_111_comb", 9'({cout1, s1}), 9'h3);
      @(posedge clk); #1;
      chk("w1_111_reg", 9'({cout1_q, s1_q}), 9'h3);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      chk("w1_rst_reg", 9'({cout1_q, s1_q}), 9'h0);
      chk("w1_rst_comb", 9'({cout1, s1}), 9'h3);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("w1_rst_hold", 9'({cout1_q, s1_q}), 9'h0);
      @(posedge clk); #1;
      chk("w1_rst_resume", 9'({cout1_q, s1_q}), 9'h3);

      // 4-bit directed vectors
      @(negedge clk);
      a4 = 4'hF; b4 = 4'h0; ci4 = 1'b1;
      #1;
      chk("w4_ripple", 9'({cout4, s4}), 9'h10);
      @(posedge clk); #1;
      chk("w4_ripple_q", 9'({cout4_q, s4_q}), 9'h10);
      @(negedge clk);
      a4 = 4'h7; b4 = 4'h8; ci4 = 1'b0;
      #1;
      chk("w4_7p8", 9'({cout4, s4}), 9'h0F);
      a4 = 4'h9; b4 = 4'hA; ci4 = 1'b1;
      #1;
      chk("w4_9pAp1", 9'({cout4, s4}), 9'h14);

      // Mid-cycle change: comb follows, register waits for the edge
      @(posedge clk); #2;
      chk("w4_mid_q_before", 9'({cout4_q, s4_q}), 9'h14);
      a4 = 4'h3; b4 = 4'h4; ci4 = 1'b0;
      #1;
      chk("w4_mid_comb", 9'({cout4, s4}), 9'h07);
      chk("w4_mid_q_hold", 9'({cout4_q, s4_q}), 9'h14);
      @(posedge clk); #1;
      chk("w4_mid_q_after", 9'({cout4_q, s4_q}), 9'h07);

      // 8-bit boundary vectors
      @(negedge clk);
      a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1;
      #1;
      chk("w8_max", 9'({cout8, s8}), 9'h1FF);
      a8 = 8'h80; b8 = 8'h80; ci8 = 1'b0;
      #1;
      chk("w8_msb", 9'({cout8, s8}), 9'h100);
      @(posedge clk);

      // 8-bit random: comb every cycle, register equals previous cycle's sum
      prev8 = 9'h100;
      for (int n = 0; n < 1000; n++) begin
         @(negedge clk);
         a8  = 8'($urandom);
         b8  = 8'($urandom);
         ci8 = 1'($urandom);
         exp8 = 9'(a8) + 9'(b8) + 9'(ci8);
         #1;
         chk($sformatf("w8_rand_comb_%0d", n), 9'({cout8, s8}), exp8);
         chk($sformatf("w8_rand_reg_%0d", n), 9'({cout8_q, s8_q}), prev8);
         prev8 = exp8;
         @(posedge clk);
      end
      #1;
      chk("w8_rand_reg_last", 9'({cout8_q, s8_q}), prev8);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
